// File: rtl/ps2_keypad_rx.sv
// PS/2 keyboard receiver: filters the device clock, deframes 11-bit frames and
// decodes scan-code set 2 make/break sequences into a 16-key Chip-8 keypad.
module ps2_keypad_rx #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 7425
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ps2_clk_pin,
  input  logic        ps2_data_pin,
  input  logic        clear_newest_key_down,
  output logic [15:0] input_keys,
  output logic [4:0]  newest_key_down,
  output logic [7:0]  scancode,
  output logic        scancode_valid,
  output logic        frame_err
);

  localparam int              TW          = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0]   TIMEOUT_MAX = TW'(TIMEOUT_CYCLES);
  localparam logic [3:0]      FILT_LAST   = 4'(FILTER_LEN - 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} rx_state_t;

  logic clk_meta, clk_sync, data_meta, data_sync;
  logic filt_level, fall;
  logic [3:0] filt_cnt;

  // NOTE: every clocked block uses non-blocking assignments so all registers
  // update from the same pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      clk_meta  <= 1'b1;
      clk_sync  <= 1'b1;
      data_meta <= 1'b1;
      data_sync <= 1'b1;
    end else begin
      clk_meta  <= ps2_clk_pin;
      clk_sync  <= clk_meta;
      data_meta <= ps2_data_pin;
      data_sync <= data_meta;
    end
  end

  // A new clock level is accepted on its FILTER_LEN-th consecutive sample.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      filt_level <= 1'b1;
      filt_cnt   <= '0;
      fall       <= 1'b0;
    end else if (clk_sync == filt_level) begin
      filt_cnt <= '0;
      fall     <= 1'b0;
    end else if (filt_cnt == FILT_LAST) begin
      filt_level <= clk_sync;
      filt_cnt   <= '0;
      fall       <= ~clk_sync;
    end else begin
      filt_cnt <= filt_cnt + 4'd1;
      fall     <= 1'b0;
    end
  end

  rx_state_t        state, state_n;
  logic [2:0]       bit_cnt, bit_cnt_n;
  logic [7:0]       shreg, shreg_n;
  logic             par_bit, par_bit_n;
  logic             byte_ok, byte_bad;
  logic [TW-1:0]    idle_cnt;

  // NOTE: every output of this block gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    state_n   = state;
    bit_cnt_n = bit_cnt;
    shreg_n   = shreg;
    par_bit_n = par_bit;
    byte_ok   = 1'b0;
    byte_bad  = 1'b0;
    if (fall) begin
      unique case (state)
        IDLE: begin
          if (!data_sync) begin
            state_n   = DATA;
            bit_cnt_n = '0;
          end else begin
            byte_bad = 1'b1;
          end
        end
        DATA: begin
          shreg_n   = {data_sync, shreg[7:1]};
          bit_cnt_n = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) state_n = PARITY;
        end
        PARITY: begin
          par_bit_n = data_sync;
          state_n   = STOP;
        end
        STOP: begin
          if (data_sync && (^{shreg, par_bit})) byte_ok  = 1'b1;
          else                                  byte_bad = 1'b1;
          state_n = IDLE;
        end
        default: state_n = IDLE;
      endcase
    end else if (state != IDLE && idle_cnt == TIMEOUT_MAX) begin
      state_n = IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= IDLE;
      bit_cnt        <= '0;
      shreg          <= '0;
      par_bit        <= 1'b0;
      idle_cnt       <= '0;
      scancode       <= '0;
      scancode_valid <= 1'b0;
      frame_err      <= 1'b0;
    end else begin
      state          <= state_n;
      bit_cnt        <= bit_cnt_n;
      shreg          <= shreg_n;
      par_bit        <= par_bit_n;
      scancode_valid <= byte_ok;
      frame_err      <= byte_bad;
      if (byte_ok) scancode <= shreg;
      if (fall)                         idle_cnt <= '0;
      else if (idle_cnt != TIMEOUT_MAX) idle_cnt <= idle_cnt + 1'b1;
    end
  end

  function automatic logic [4:0] key_lookup(input logic [7:0] code);
    case (code)
      8'h16: key_lookup = 5'h11;  8'h1E: key_lookup = 5'h12;
      8'h26: key_lookup = 5'h13;  8'h25: key_lookup = 5'h1C;
      8'h15: key_lookup = 5'h14;  8'h1D: key_lookup = 5'h15;
      8'h24: key_lookup = 5'h16;  8'h2D: key_lookup = 5'h1D;
      8'h1C: key_lookup = 5'h17;  8'h1B: key_lookup = 5'h18;
      8'h23: key_lookup = 5'h19;  8'h2B: key_lookup = 5'h1E;
      8'h1A: key_lookup = 5'h1A;  8'h22: key_lookup = 5'h10;
      8'h21: key_lookup = 5'h1B;  8'h2A: key_lookup = 5'h1F;
      default: key_lookup = 5'h00;
    endcase
  endfunction

  logic       key_hit;
  logic [3:0] key_idx;
  logic       ext, brk;

  always_comb begin
    {key_hit, key_idx} = key_lookup(scancode);
  end

  // A press load is written after the clear so it wins when both coincide.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      input_keys      <= '0;
      newest_key_down <= '0;
      ext             <= 1'b0;
      brk             <= 1'b0;
    end else begin
      if (clear_newest_key_down) newest_key_down[4] <= 1'b0;
      if (frame_err) begin
        ext <= 1'b0;
        brk <= 1'b0;
      end else if (scancode_valid) begin
        if (scancode == 8'hE0) begin
          ext <= 1'b1;
        end else if (scancode == 8'hF0) begin
          brk <= 1'b1;
        end else begin
          ext <= 1'b0;
          brk <= 1'b0;
          if (!ext && key_hit) begin
            if (brk) begin
              input_keys[key_idx] <= 1'b0;
            end else begin
              input_keys[key_idx] <= 1'b1;
              if (!input_keys[key_idx]) newest_key_down <= {1'b1, key_idx};
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_ps2_keypad_rx.sv
// Self-checking bench for ps2_keypad_rx: spec vector table, hand-written corner
// sequences and random frames checked against a byte-level keypad model.
module tb_ps2_keypad_rx;

  localparam int HALF = 20;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ps2_clk_pin = 1'b1;
  logic        ps2_data_pin = 1'b1;
  logic        clear_newest_key_down = 1'b0;
  logic [15:0] input_keys;
  logic [4:0]  newest_key_down;
  logic [7:0]  scancode;
  logic        scancode_valid;
  logic        frame_err;

  ps2_keypad_rx #(.FILTER_LEN(4), .TIMEOUT_CYCLES(400)) dut (
    .clk                   (clk),
    .rst                   (rst),
    .ps2_clk_pin           (ps2_clk_pin),
    .ps2_data_pin          (ps2_data_pin),
    .clear_newest_key_down (clear_newest_key_down),
    .input_keys            (input_keys),
    .newest_key_down       (newest_key_down),
    .scancode              (scancode),
    .scancode_valid        (scancode_valid),
    .frame_err             (frame_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int vcnt  = 0;
  int ecnt  = 0;

  always @(negedge clk) begin
    if (rst) begin
      if (scancode_valid) vcnt++;
      if (frame_err)      ecnt++;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Byte-level model of the keypad decoder.
  logic [7:0]  kmap [16] = '{8'h22, 8'h16, 8'h1E, 8'h26, 8'h15, 8'h1D, 8'h24, 8'h1C,
                             8'h1B, 8'h23, 8'h1A, 8'h21, 8'h25, 8'h2D, 8'h2B, 8'h2A};
  logic [15:0] m_keys = '0;
  logic [4:0]  m_nkd  = '0;
  bit          m_ext  = 0;
  bit          m_brk  = 0;

  function automatic int find_key(input logic [7:0] b);
    for (int i = 0; i < 16; i++) if (kmap[i] == b) return i;
    return -1;
  endfunction

  task automatic model_byte(input logic [7:0] b);
    int k;
    if (b == 8'hE0) m_ext = 1;
    else if (b == 8'hF0) m_brk = 1;
    else begin
      k = find_key(b);
      if (!m_ext && k >= 0) begin
        if (m_brk) m_keys[k] = 1'b0;
        else begin
          if (!m_keys[k]) m_nkd = {1'b1, 4'(k)};
          m_keys[k] = 1'b1;
        end
      end
      m_ext = 0;
      m_brk = 0;
    end
  endtask

  task automatic model_reset();
    m_keys = '0; m_nkd = '0; m_ext = 0; m_brk = 0;
  endtask

  function automatic logic [10:0] frame_bits(input logic [7:0] code, input bit perr, input bit serr);
    return {~serr, (~^code) ^ perr, code, 1'b0};
  endfunction

  // Device drives data while the clock is high, then pulls the clock low.
  task automatic send_bits(input logic [10:0] bits, input int first, input int last, input int glitch_at);
    for (int i = first; i <= last; i++) begin
      @(negedge clk); ps2_data_pin = bits[i];
      repeat (HALF / 2) @(negedge clk);
      ps2_clk_pin = 1'b0;
      repeat (HALF) @(negedge clk);
      ps2_clk_pin = 1'b1;
      repeat (HALF / 2) @(negedge clk);
      if (i == glitch_at) begin
        ps2_clk_pin = 1'b0;
        repeat (3) @(negedge clk);
        ps2_clk_pin = 1'b1;
        repeat (5) @(negedge clk);
      end
    end
    if (last == 10) ps2_data_pin = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] code, input bit perr, input bit serr);
    send_bits(frame_bits(code, perr, serr), 0, 10, -1);
    if (perr || serr) begin m_ext = 0; m_brk = 0; end
    else model_byte(code);
  endtask

  task automatic pulse_clear();
    @(negedge clk); clear_newest_key_down = 1'b1;
    @(negedge clk); clear_newest_key_down = 1'b0;
    m_nkd[4] = 1'b0;
    @(negedge clk);
  endtask

  typedef struct {
    logic [7:0]  code;
    bit          perr;
    bit          serr;
    bit          clr;
    int          exp_v;
    int          exp_e;
    logic [15:0] exp_keys;
    logic [4:0]  exp_nkd;
  } vec_t;

  vec_t vecs[$];

  task automatic add_vec(input logic [7:0] code, input bit perr, input bit serr, input bit clr,
                         input int ev, input int ee, input logic [15:0] ek, input logic [4:0] en);
    vec_t v;
    v.code = code; v.perr = perr; v.serr = serr; v.clr = clr;
    v.exp_v = ev; v.exp_e = ee; v.exp_keys = ek; v.exp_nkd = en;
    vecs.push_back(v);
  endtask

  logic [7:0] pool [20] = '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h15, 8'h1D, 8'h24, 8'h2D, 8'h1C, 8'h1B,
                            8'h23, 8'h2B, 8'h1A, 8'h22, 8'h21, 8'h2A, 8'hF0, 8'hF0, 8'hE0, 8'h5A};

  initial begin
    int v0, e0, waited;
    bit seen, perr;
    logic [7:0] code;

    add_vec(8'h1C, 0, 0, 0, 1, 0, 16'h0080, 5'h17);
    add_vec(8'hF0, 0, 0, 0, 1, 0, 16'h0080, 5'h17);
    add_vec(8'h1C, 0, 0, 1, 1, 0, 16'h0000, 5'h07);
    add_vec(8'h22, 0, 0, 0, 1, 0, 16'h0001, 5'h10);
    add_vec(8'h22, 0, 0, 0, 1, 0, 16'h0001, 5'h10);
    add_vec(8'h22, 0, 0, 1, 1, 0, 16'h0001, 5'h00);
    add_vec(8'h22, 0, 0, 0, 1, 0, 16'h0001, 5'h00);
    add_vec(8'h2A, 0, 0, 0, 1, 0, 16'h8001, 5'h1F);
    add_vec(8'h16, 1, 0, 0, 0, 1, 16'h8001, 5'h1F);
    add_vec(8'h16, 0, 1, 0, 0, 1, 16'h8001, 5'h1F);
    add_vec(8'hE0, 0, 0, 0, 1, 0, 16'h8001, 5'h1F);
    add_vec(8'h16, 0, 0, 0, 1, 0, 16'h8001, 5'h1F);
    add_vec(8'hF0, 0, 0, 0, 1, 0, 16'h8001, 5'h1F);
    add_vec(8'h2A, 0, 0, 0, 1, 0, 16'h0001, 5'h1F);
    add_vec(8'h5A, 0, 0, 0, 1, 0, 16'h0001, 5'h1F);

    repeat (3) @(negedge clk);
    check("reset_outputs", {1'b0, input_keys, newest_key_down, scancode, scancode_valid, frame_err}, 32'h0);
    rst = 1'b1;
    repeat (5) @(negedge clk);

    foreach (vecs[i]) begin
      v0 = vcnt; e0 = ecnt;
      send_frame(vecs[i].code, vecs[i].perr, vecs[i].serr);
      if (vecs[i].clr) pulse_clear();
      check($sformatf("vec%0d_valid", i), vcnt - v0, vecs[i].exp_v);
      check($sformatf("vec%0d_err", i), ecnt - e0, vecs[i].exp_e);
      check($sformatf("vec%0d_keys", i), input_keys, vecs[i].exp_keys);
      check($sformatf("vec%0d_nkd", i), newest_key_down, vecs[i].exp_nkd);
      if (vecs[i].exp_v == 1) check($sformatf("vec%0d_code", i), scancode, vecs[i].code);
    end

    for (int n = 0; n < 40; n++) begin
      code = pool[$urandom_range(0, 19)];
      perr = ($urandom_range(0, 9) == 0);
      v0 = vcnt; e0 = ecnt;
      send_frame(code, perr, 1'b0);
      if ($urandom_range(0, 3) == 0) pulse_clear();
      check($sformatf("rnd%0d_valid", n), vcnt - v0, perr ? 0 : 1);
      check($sformatf("rnd%0d_err", n), ecnt - e0, perr ? 1 : 0);
      check($sformatf("rnd%0d_keys", n), input_keys, m_keys);
      check($sformatf("rnd%0d_nkd", n), newest_key_down, m_nkd);
    end

    // Asynchronous reset in the middle of a frame.
    send_frame(8'h1A, 0, 0);
    send_bits(frame_bits(8'hFF, 0, 0), 0, 1, -1);
    #3 rst = 1'b0;
    #1 check("async_reset_outputs", {1'b0, input_keys, newest_key_down, scancode, scancode_valid, frame_err}, 32'h0);
    model_reset();
    repeat (3) @(negedge clk);
    rst = 1'b1;
    v0 = vcnt; e0 = ecnt;
    send_bits(frame_bits(8'hFF, 0, 0), 2, 10, -1);
    check("post_reset_errs", ecnt - e0, 9);
    check("post_reset_valid", vcnt - v0, 0);
    check("post_reset_keys", input_keys, 16'h0000);

    // Partial frame abandoned by timeout, then a clean frame.
    v0 = vcnt; e0 = ecnt;
    send_bits(frame_bits(8'h1C, 0, 0), 0, 3, -1);
    repeat (1000) @(negedge clk);
    send_frame(8'h26, 0, 0);
    check("timeout_valid", vcnt - v0, 1);
    check("timeout_err", ecnt - e0, 0);
    check("timeout_keys", input_keys, 16'h0008);
    check("timeout_nkd", newest_key_down, 5'h13);

    // Short low glitch on the clock pin between bits of a frame.
    v0 = vcnt; e0 = ecnt;
    send_bits(frame_bits(8'h1E, 0, 0), 0, 10, 4);
    model_byte(8'h1E);
    check("glitch_valid", vcnt - v0, 1);
    check("glitch_err", ecnt - e0, 0);
    check("glitch_code", scancode, 8'h1E);
    check("glitch_keys", input_keys, m_keys);

    // Clear request landing in the same cycle as a new-press load.
    seen = 0; waited = 0;
    fork
      send_frame(8'h15, 0, 0);
      begin
        while (!seen && waited < 2000) begin
          @(negedge clk);
          waited++;
          if (scancode_valid) begin
            seen = 1;
            clear_newest_key_down = 1'b1;
            @(negedge clk);
            clear_newest_key_down = 1'b0;
          end
        end
      end
    join
    check("race_seen", seen, 1);
    check("race_nkd", newest_key_down, 5'h14);
    check("race_keys", input_keys, m_keys);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
